demux_rr_scheduler: RTL

Round-robin dispatcher that sequences a 1-to-N demultiplexer: accepts words from one valid/ready input stream, latches each into a single holding register and steers it to one of N output channels in rotating order, skipping masked channels. A per-word timeout re-steers a word whose target channel stalls. It sits between a single producer and N consumers, generating the demux select, the data register and the per-channel valid strobes.

---
 rtl/demux_pkg.sv | 16 +
 rtl/rr_next_sel.sv | 28 ++
 rtl/demux_rr_scheduler.sv | 134 +++++++++++++
 3 files changed

// File: rtl/demux_pkg.sv
// Shared types and constants for the round-robin demux scheduler.
package demux_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam logic [7:0] RESTEER_MAX = 8'd255;

    // Select width for n channels; never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_next_sel.sv
// Round-robin search: first enabled channel strictly after ptr_i, wrapping,
// with ptr_i itself considered last.
module rr_next_sel #(
    parameter int N_OUT = 4,
    parameter int SEL_W = 2
) (
    input  logic [SEL_W-1:0] ptr_i,
    input  logic [N_OUT-1:0] mask_i,
    output logic [SEL_W-1:0] idx_o,
    output logic             found_o
);

    always_comb begin
        logic [SEL_W-1:0] cand;
        // NOTE: every output gets a default first so no path infers a latch.
        idx_o   = '0;
        found_o = 1'b0;
        cand    = '0;
        for (int k = 1; k <= N_OUT; k++) begin
            cand = SEL_W'((int'(ptr_i) + k) % N_OUT);
            if (!found_o && mask_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/demux_rr_scheduler.sv
// Single-register round-robin dispatcher steering one input stream onto
// N one-hot output channels, with timeout-driven re-steering of stalled words.
module demux_rr_scheduler
    import demux_pkg::*;
#(
    parameter  int N_OUT   = 4,
    parameter  int DATA_W  = 8,
    parameter  int TIMEOUT = 16,
    localparam int SEL_W   = sel_width(N_OUT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic [N_OUT-1:0]  ch_mask,
    output logic [DATA_W-1:0] out_data,
    output logic [N_OUT-1:0]  out_valid,
    input  logic [N_OUT-1:0]  out_ready,
    output logic [SEL_W-1:0]  sel,
    output logic [7:0]        resteer_cnt
);

    localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [SEL_W-1:0]    last_q, last_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [7:0]          resteer_q, resteer_d;
    logic [N_OUT-1:0]    out_valid_q, out_valid_d;

    logic [SEL_W-1:0]    search_ptr;
    logic [SEL_W-1:0]    next_idx;
    logic                next_found;
    logic                mask_any;
    logic                xfer_in;
    logic                xfer_out;
    logic                timeout_hit;

    // One search unit: from `last` when empty, from the committed `sel` when holding.
    assign search_ptr = (state_q == HOLD) ? sel_q : last_q;

    rr_next_sel #(
        .N_OUT (N_OUT),
        .SEL_W (SEL_W)
    ) u_next_sel (
        .ptr_i   (search_ptr),
        .mask_i  (ch_mask),
        .idx_o   (next_idx),
        .found_o (next_found)
    );

    assign mask_any    = |ch_mask;
    assign xfer_out    = (state_q == HOLD) && out_ready[sel_q];
    assign in_ready    = (state_q == HOLD) ? (out_ready[sel_q] && mask_any) : mask_any;
    assign xfer_in     = in_valid && in_ready;
    assign timeout_hit = (TIMEOUT > 0) && (state_q == HOLD) && !xfer_out && (cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        last_d    = last_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        resteer_d = resteer_q;

        unique case (state_q)
            IDLE: begin
                if (xfer_in) begin
                    data_d  = in_data;
                    sel_d   = next_idx;
                    cnt_d   = '0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (xfer_out) begin
                    last_d = sel_q;
                    cnt_d  = '0;
                    if (xfer_in) begin
                        data_d = in_data;
                        sel_d  = next_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (timeout_hit) begin
                    if (next_found) begin
                        sel_d = next_idx;
                    end
                    cnt_d = '0;
                    if (resteer_q != RESTEER_MAX) begin
                        resteer_d = resteer_q + 8'd1;
                    end
                end else if (TIMEOUT > 0) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Strobe is built from next-state so it lands on the same edge as `sel`.
        out_valid_d = (state_d == HOLD) ? (N_OUT'(1) << sel_d) : '0;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            last_q      <= SEL_W'(N_OUT - 1);
            data_q      <= '0;
            cnt_q       <= '0;
            resteer_q   <= '0;
            out_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            resteer_q   <= resteer_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data    = data_q;
    assign out_valid   = out_valid_q;
    assign sel         = sel_q;
    assign resteer_cnt = resteer_q;

endmodule
